// File: rtl/showdown_sequencer_if.sv
// showdown_sequencer_if: control, evaluator and result signals of one showdown sequencer
// master: game-flow/evaluator side; drives start, abort, clear_score and the evaluator level/ranks.
// slave:  the sequencer; drives eval_sel, busy, done, winner, tie, p1_score, p2_score, match_over.
interface showdown_sequencer_if #(
  parameter int SCORE_W = 4
) ();
  logic               start;
  logic               abort;
  logic               clear_score;
  logic [2:0]         eval_card_level;
  logic [3:0]         eval_max_num_1;
  logic [3:0]         eval_max_num_2;
  logic [3:0]         eval_max_num_3;
  logic [3:0]         eval_max_num_4;
  logic               eval_sel;
  logic               busy;
  logic               done;
  logic               winner;
  logic               tie;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               match_over;
  modport master (
    output start, abort, clear_score,
    output eval_card_level, eval_max_num_1, eval_max_num_2, eval_max_num_3, eval_max_num_4,
    input  eval_sel, busy, done, winner, tie, p1_score, p2_score, match_over
  );
  modport slave (
    input  start, abort, clear_score,
    input  eval_card_level, eval_max_num_1, eval_max_num_2, eval_max_num_3, eval_max_num_4,
    output eval_sel, busy, done, winner, tie, p1_score, p2_score, match_over
  );
endinterface

// File: rtl/showdown_sequencer.sv
// showdown_sequencer: time-shares one hand evaluator between two players and scores the showdown
// Ports: clk; rst_n (asynchronous, active-low); bus (showdown_sequencer_if.slave) carrying the
//   start/abort/clear_score controls, evaluator level and ranks in, eval_sel out, and the
//   busy/done/winner/tie/p1_score/p2_score/match_over status.
// Build option: define SHOWDOWN_TIE_EN to report full ties on tie (no score change) instead of
//   awarding them to player 2.
module showdown_sequencer #(
  parameter int EVAL_LAT   = 1,
  parameter int SCORE_W    = 4,
  parameter int WIN_TARGET = 5
) (
  input logic clk,
  input logic rst_n,
  showdown_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEL_P1, SEL_P2, CMP, DONE} state_t;
  localparam logic [3:0]         LAT    = 4'(EVAL_LAT);
  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);
  localparam logic [SCORE_W-1:0] SAT    = '1;
  state_t             state, state_nx;
  logic [3:0]         wait_cnt, wait_cnt_nx;
  logic               cap_p1, cap_p2, upd;
  logic [18:0]        eval_key, p1_key, p2_key;
  logic               p1_win, p2_win, tie_nx;
  logic               winner_q, tie_q, match_over_q;
  logic [SCORE_W-1:0] p1_q, p2_q, p1_nx, p2_nx;
  // Level occupies the top bits and ranks follow most significant first, so a single
  // unsigned compare gives level-then-rank precedence.
  assign eval_key = {bus.eval_card_level, bus.eval_max_num_1, bus.eval_max_num_2,
                     bus.eval_max_num_3, bus.eval_max_num_4};
  assign p1_win = p1_key > p2_key;
`ifdef SHOWDOWN_TIE_EN
  assign tie_nx = p1_key == p2_key;
`else
  assign tie_nx = 1'b0;
`endif
  // Without tie reporting an exact tie falls through to player 2.
  assign p2_win = !p1_win && !tie_nx;
  assign p1_nx  = p1_win && p1_q != SAT ? p1_q + 1'b1 : p1_q;
  assign p2_nx  = p2_win && p2_q != SAT ? p2_q + 1'b1 : p2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    cap_p1      = 1'b0;
    cap_p2      = 1'b0;
    upd         = 1'b0;
    case (state)
      IDLE: if (bus.start && !bus.abort && !match_over_q) begin
        state_nx    = SEL_P1;
        wait_cnt_nx = '0;
      end
      SEL_P1: begin
        state_nx    = bus.abort ? IDLE : wait_cnt == LAT ? SEL_P2 : SEL_P1;
        wait_cnt_nx = bus.abort || wait_cnt == LAT ? 4'd0 : wait_cnt + 4'd1;
        cap_p1      = !bus.abort && wait_cnt == LAT;
      end
      SEL_P2: begin
        state_nx    = bus.abort ? IDLE : wait_cnt == LAT ? CMP : SEL_P2;
        wait_cnt_nx = bus.abort || wait_cnt == LAT ? 4'd0 : wait_cnt + 4'd1;
        cap_p2      = !bus.abort && wait_cnt == LAT;
      end
      CMP: begin
        state_nx = bus.abort ? IDLE : DONE;
        upd      = !bus.abort;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_key       <= '0;
      p2_key       <= '0;
      winner_q     <= 1'b0;
      tie_q        <= 1'b0;
      p1_q         <= '0;
      p2_q         <= '0;
      match_over_q <= 1'b0;
    end else begin
      if (cap_p1) p1_key <= eval_key;
      if (cap_p2) p2_key <= eval_key;
      if (upd) begin
        winner_q <= p2_win;
        tie_q    <= tie_nx;
      end
      if (bus.clear_score) begin
        p1_q         <= '0;
        p2_q         <= '0;
        match_over_q <= 1'b0;
      end else if (upd) begin
        p1_q         <= p1_nx;
        p2_q         <= p2_nx;
        match_over_q <= match_over_q || p1_nx >= TARGET || p2_nx >= TARGET;
      end
    end
  end
  assign bus.eval_sel   = state == SEL_P2;
  assign bus.busy       = state != IDLE;
  assign bus.done       = state == DONE;
  assign bus.winner     = winner_q;
  assign bus.tie        = tie_q;
  assign bus.p1_score   = p1_q;
  assign bus.p2_score   = p2_q;
  assign bus.match_over = match_over_q;
endmodule
